// File: rtl/sp_ram_bytewr_if.sv
// Bus bundle for sp_ram_bytewr.
//   master: drives cs/we/oe/addr/be/wdata/clr_req, receives rdata/rvalid/busy
//   slave : the RAM side, mirror image of master
interface sp_ram_bytewr_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) ();
  logic                      cs;
  logic                      we;
  logic                      oe;
  logic [ADDR_WIDTH-1:0]     addr;
  logic [DATA_WIDTH/8-1:0]   be;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH-1:0]     rdata;
  logic                      rvalid;
  logic                      clr_req;
  logic                      busy;

  modport master (
    output cs, we, oe, addr, be, wdata, clr_req,
    input  rdata, rvalid, busy
  );

  modport slave (
    input  cs, we, oe, addr, be, wdata, clr_req,
    output rdata, rvalid, busy
  );
endinterface

// File: rtl/sp_ram_bytewr.sv
// Single-port RAM with per-byte write enables, registered read with 1 or 2
// cycles of latency plus a valid strobe, optional write-first read-back, and a
// clear engine that sweeps CLR_VALUE over every location.
//   clk_i   rising-edge clock
//   rst_i   asynchronous active-high reset (array contents are kept)
//   bus     sp_ram_bytewr_if.slave: cs/we/oe/addr/be/wdata/clr_req in,
//           rdata/rvalid/busy out
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | user accesses served; clr_req starts a sweep
// ST_CLEAR | one location cleared per cycle, user accesses ignored
module sp_ram_bytewr #(
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    ADDR_WIDTH   = 4,
  parameter int                    DEPTH        = 16,
  parameter int                    READ_LATENCY = 1,
  parameter int                    WRITE_MODE   = 0,
  parameter logic [DATA_WIDTH-1:0] CLR_VALUE    = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  sp_ram_bytewr_if.slave  bus
);

  localparam int NB = DATA_WIDTH / 8;
  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  busy;
  logic                  clr_we;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  in_range;
  logic                  usr_wr;
  logic                  usr_rd;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] merged_word;
  logic                  s1_vld_d, s1_vld_q;
  logic [DATA_WIDTH-1:0] s1_data_d, s1_data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.clr_req) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clr_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    clr_we = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.busy = busy;

  assign in_range = ({1'b0, bus.addr} < DEPTH_EXT);
  assign usr_wr   = !busy && bus.cs && bus.we;
  assign usr_rd   = !busy && bus.cs && !bus.we && bus.oe;
  assign rd_word  = in_range ? mem[bus.addr] : '0;

  // Old word with the enabled bytes replaced; the write-first read-back value.
  always_comb begin
    merged_word = rd_word;
    for (int k = 0; k < NB; k++) begin
      if (bus.be[k]) merged_word[8*k +: 8] = bus.wdata[8*k +: 8];
    end
  end

  // The array carries no reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      mem[clr_cnt_q] <= CLR_VALUE;
    end else if (usr_wr && in_range) begin
      for (int k = 0; k < NB; k++) begin
        if (bus.be[k]) mem[bus.addr][8*k +: 8] <= bus.wdata[8*k +: 8];
      end
    end
  end

  assign s1_vld_d  = usr_rd || ((WRITE_MODE == 1) && usr_wr);
  assign s1_data_d = usr_wr ? (in_range ? merged_word : '0) : rd_word;

  // Data registers only load on a valid response so rdata holds otherwise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_vld_q  <= 1'b0;
      s1_data_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      if (s1_vld_d) s1_data_q <= s1_data_d;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s2_vld_q;
      logic [DATA_WIDTH-1:0] s2_data_q;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          s2_vld_q  <= 1'b0;
          s2_data_q <= '0;
        end else begin
          s2_vld_q <= s1_vld_q;
          if (s1_vld_q) s2_data_q <= s1_data_q;
        end
      end

      assign bus.rvalid = s2_vld_q;
      assign bus.rdata  = s2_data_q;
    end else begin : g_lat1
      assign bus.rvalid = s1_vld_q;
      assign bus.rdata  = s1_data_q;
    end
  endgenerate

endmodule

// File: tb/tb_sp_ram_bytewr.sv
// Bench for sp_ram_bytewr. Two instances share one stimulus stream:
//   A: DEPTH=16, READ_LATENCY=1, WRITE_MODE=0, CLR_VALUE=16'h00FF
//   B: DEPTH=12, READ_LATENCY=2, WRITE_MODE=1, CLR_VALUE=16'h00FF
// A behavioural model per instance pushes expected responses into a queue
// tagged with the cycle they are due; the outputs are sampled 1 time unit
// after each rising edge and compared against the queue head.
module tb_sp_ram_bytewr;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs, we, oe, clr_req;
  logic [3:0]  addr;
  logic [1:0]  be;
  logic [15:0] wdata;

  sp_ram_bytewr_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) if_a ();
  sp_ram_bytewr_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) if_b ();

  assign if_a.cs = cs;  assign if_a.we = we;  assign if_a.oe = oe;
  assign if_a.addr = addr;  assign if_a.be = be;  assign if_a.wdata = wdata;
  assign if_a.clr_req = clr_req;
  assign if_b.cs = cs;  assign if_b.we = we;  assign if_b.oe = oe;
  assign if_b.addr = addr;  assign if_b.be = be;  assign if_b.wdata = wdata;
  assign if_b.clr_req = clr_req;

  sp_ram_bytewr #(
    .DATA_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(16),
    .READ_LATENCY(1), .WRITE_MODE(0), .CLR_VALUE(16'h00FF)
  ) u_dut_a (
    .clk_i(clk), .rst_i(rst), .bus(if_a)
  );

  sp_ram_bytewr #(
    .DATA_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(12),
    .READ_LATENCY(2), .WRITE_MODE(1), .CLR_VALUE(16'h00FF)
  ) u_dut_b (
    .clk_i(clk), .rst_i(rst), .bus(if_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] data;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [15:0] m_mem [2][16];
  logic        m_busy [2];
  int          m_cnt [2];
  logic [15:0] m_last [2];
  int          cyc = 0;
  int          busy_cnt_a = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  function automatic int depth_of(input int d);
    return (d == 0) ? 16 : 12;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic int wm_of(input int d);
    return (d == 0) ? 0 : 1;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push_exp(input int d, input logic [15:0] v);
    exp_t e;
    e.due  = cyc + lat_of(d) - 1;
    e.data = v;
    if (d == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  // Applies one rising edge to the model of instance d using the inputs
  // that the DUT sees on that same edge.
  task automatic model_edge(input int d);
    logic [15:0] old_w, mrg;
    int          ia;
    bit          inr;
    ia  = int'(addr);
    inr = (ia < depth_of(d));
    if (!m_busy[d]) begin
      if (cs && we) begin
        old_w = inr ? m_mem[d][ia] : 16'h0000;
        mrg   = old_w;
        if (be[0]) mrg[7:0]  = wdata[7:0];
        if (be[1]) mrg[15:8] = wdata[15:8];
        if (inr) m_mem[d][ia] = mrg;
        if (wm_of(d) == 1) push_exp(d, inr ? mrg : 16'h0000);
      end else if (cs && oe) begin
        push_exp(d, inr ? m_mem[d][ia] : 16'h0000);
      end
      if (clr_req) begin
        m_busy[d] = 1'b1;
        m_cnt[d]  = 0;
      end
    end else begin
      m_mem[d][m_cnt[d]] = 16'h00FF;
      if (m_cnt[d] == depth_of(d) - 1) m_busy[d] = 1'b0;
      else                             m_cnt[d]++;
    end
  endtask

  task automatic check_dut(input int d);
    logic        rv, bsy;
    logic [15:0] rd;
    exp_t        e;
    bit          have;
    string       nm;
    nm   = (d == 0) ? "a" : "b";
    rv   = (d == 0) ? if_a.rvalid : if_b.rvalid;
    rd   = (d == 0) ? if_a.rdata  : if_b.rdata;
    bsy  = (d == 0) ? if_a.busy   : if_b.busy;
    have = 1'b0;
    check_val($sformatf("%s.busy@%0d", nm, cyc), {31'd0, bsy}, {31'd0, m_busy[d]});
    if (d == 0 && q_a.size() > 0 && q_a[0].due <= cyc) begin
      e = q_a.pop_front();
      have = 1'b1;
    end
    if (d == 1 && q_b.size() > 0 && q_b[0].due <= cyc) begin
      e = q_b.pop_front();
      have = 1'b1;
    end
    if (have) begin
      check_val($sformatf("%s.rvalid@%0d", nm, cyc), {31'd0, rv}, 32'd1);
      check_val($sformatf("%s.rdata@%0d", nm, cyc), {16'd0, rd}, {16'd0, e.data});
      m_last[d] = e.data;
    end else begin
      check_val($sformatf("%s.no_rvalid@%0d", nm, cyc), {31'd0, rv}, 32'd0);
      check_val($sformatf("%s.rdata_hold@%0d", nm, cyc), {16'd0, rd}, {16'd0, m_last[d]});
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge(0);
    model_edge(1);
    #1;
    check_dut(0);
    check_dut(1);
    if (if_a.busy) busy_cnt_a++;
  endtask

  task automatic idle();
    cs = 1'b0; we = 1'b0; oe = 1'b0; clr_req = 1'b0;
    addr = 4'd0; be = 2'b00; wdata = 16'h0000;
  endtask

  task automatic wr(input int a, input logic [15:0] d, input logic [1:0] b);
    cs = 1'b1; we = 1'b1; oe = 1'b0; clr_req = 1'b0;
    addr = 4'(a); wdata = d; be = b;
    step();
  endtask

  task automatic rd(input int a);
    cs = 1'b1; we = 1'b0; oe = 1'b1; clr_req = 1'b0;
    addr = 4'(a); be = 2'b00; wdata = 16'h0000;
    step();
  endtask

  task automatic nop(input int n);
    idle();
    repeat (n) step();
  endtask

  // Asserts reset between edges, checks the async effect, releases it
  // before the next edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 1'b0;
      m_cnt[d]  = 0;
      m_last[d] = 16'h0000;
    end
    q_a.delete();
    q_b.delete();
    check_dut(0);
    check_dut(1);
    rst = 1'b0;
  endtask

  initial begin
    idle();
    do_reset();

    // Fill and read back to back.
    for (int i = 0; i < 16; i++) wr(i, 16'hA500 + 16'(i), 2'b11);
    for (int i = 0; i < 16; i++) begin
      rd(i);
      check_val($sformatf("fill_a[%0d]", i), {16'd0, if_a.rdata}, {16'd0, 16'hA500 + 16'(i)});
    end
    nop(3);

    // Byte enables.
    wr(3, 16'h1234, 2'b11);
    wr(3, 16'hABCD, 2'b10);
    rd(3);
    check_val("be_merge_a", {16'd0, if_a.rdata}, {16'd0, 16'hAB34});
    wr(3, 16'hFFFF, 2'b00);
    rd(3);
    check_val("be_none_a", {16'd0, if_a.rdata}, {16'd0, 16'hAB34});
    nop(2);

    // Write-first on B, no-change on A.
    wr(5, 16'h1100, 2'b11);
    wr(5, 16'hBEEF, 2'b01);
    check_val("wm0_no_rvalid_a", {31'd0, if_a.rvalid}, 32'd0);
    nop(1);
    check_val("wm1_rvalid_b", {31'd0, if_b.rvalid}, 32'd1);
    check_val("wm1_rdata_b", {16'd0, if_b.rdata}, {16'd0, 16'h11EF});
    nop(2);

    // Deselected / read disabled for 10 cycles.
    idle(); oe = 1'b1; addr = 4'd2;
    repeat (10) step();
    cs = 1'b1; oe = 1'b0;
    repeat (3) step();

    // Clear sweep with a read in flight and ignored accesses while busy.
    cs = 1'b1; we = 1'b0; oe = 1'b1; addr = 4'd7; clr_req = 1'b1;
    busy_cnt_a = 0;
    step();
    for (int j = 0; j < 16; j++) begin
      cs = 1'b1; we = 1'b1; oe = 1'b0; addr = 4'(j);
      wdata = 16'hDEAD; be = 2'b11;
      clr_req = (j >= 2 && j < 6);
      step();
    end
    nop(2);
    check_val("busy_len_a", 32'(busy_cnt_a), 32'd16);
    for (int i = 0; i < 16; i++) begin
      rd(i);
      check_val($sformatf("clr_a[%0d]", i), {16'd0, if_a.rdata}, {16'd0, 16'h00FF});
    end
    nop(3);

    // Reset in the middle of a sweep.
    for (int i = 0; i < 16; i++) wr(i, 16'hC000 + 16'(i), 2'b11);
    idle(); clr_req = 1'b1;
    step();
    idle();
    repeat (5) step();
    do_reset();
    check_val("rst_busy_a", {31'd0, if_a.busy}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      rd(i);
      check_val($sformatf("partial_a[%0d]", i), {16'd0, if_a.rdata},
                {16'd0, (i < 5) ? 16'h00FF : 16'hC000 + 16'(i)});
    end
    nop(3);

    // Out-of-range on B (DEPTH=12), in range on A.
    wr(13, 16'h5A5A, 2'b11);
    rd(13);
    check_val("oor_a", {16'd0, if_a.rdata}, {16'd0, 16'h5A5A});
    nop(1);
    check_val("oor_rvalid_b", {31'd0, if_b.rvalid}, 32'd1);
    check_val("oor_rdata_b", {16'd0, if_b.rdata}, 32'd0);
    for (int i = 0; i < 12; i++) rd(i);
    nop(3);

    // Write to address 0 in the clr_req cycle is overwritten by the sweep.
    cs = 1'b1; we = 1'b1; oe = 1'b0; addr = 4'd0;
    wdata = 16'h1111; be = 2'b11; clr_req = 1'b1;
    step();
    nop(18);
    rd(0);
    check_val("clr_over_wr_a", {16'd0, if_a.rdata}, {16'd0, 16'h00FF});
    nop(4);

    check_val("q_a_drained", 32'(q_a.size()), 32'd0);
    check_val("q_b_drained", 32'(q_b.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sp_ram_bytewr.md
Name: sp_ram_bytewr

Overview:
- Parametrised successor to the team's single-port synchronous RAM.
- Adds the following over the current RAM:
  - split write/read data buses instead of a tristate data bus;
  - per-byte write enables;
  - selectable read latency (1 or 2) with a valid strobe;
  - selectable read-during-write mode;
  - a hardware clear engine that sweeps the whole array.
- Sits between datapath masters and on-chip storage. It is the default scratch/buffer memory for new blocks.

Parameters:
- DATA_WIDTH, 16, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 4, address width.
- DEPTH, 16, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH.
- READ_LATENCY, 1, cycles from read request edge to rdata/rvalid; legal values 1 or 2.
- WRITE_MODE, 0:
  - 0 = no-change: a write cycle does not update rdata/rvalid;
  - 1 = write-first: a write cycle returns the merged new word on rdata, with rvalid.
- CLR_VALUE, 0, word written to every location by the clear engine.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- cs  in  1  chip select; access only when 1
- we  in  1  1 = write, 0 = read (when cs=1)
- oe  in  1  read enable; a read needs cs=1, we=0, oe=1
- addr  in  ADDR_WIDTH  word address
- be  in  DATA_WIDTH/8  byte enables for writes; be[k] covers wdata[8k+7:8k]
- wdata  in  DATA_WIDTH  write data
- rdata  out  DATA_WIDTH  read data, registered
- rvalid  out  1  one-cycle strobe; rdata is valid for this request
- clr_req  in  1  start clear sweep (level sampled at edge)
- busy  out  1  clear sweep in progress

Behaviour:
- Reset (async, rst=1):
  - rdata=0, rvalid=0, busy=0;
  - FSM to IDLE, clear counter=0, latency pipeline flushed.
  - Array contents are NOT reset.
  - Release is synchronous to the next clk edge.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clr_req=1 at an edge.
  - CLEAR -> IDLE after writing location DEPTH-1.
- CLEAR state:
  - One location written per cycle, at addresses 0,1,..,DEPTH-1, with CLR_VALUE on all bytes.
  - busy=1 from the edge after clr_req is sampled, through the edge that writes DEPTH-1; busy=0 on the following cycle.
  - Sweep length is exactly DEPTH cycles.
  - While busy=1, all user accesses (cs) are ignored: no write, no rvalid.
  - clr_req while busy=1 is ignored.
  - Read responses already in the latency pipeline when the sweep starts still complete.
- Write (IDLE, cs=1, we=1):
  - At the edge, mem[addr] byte k is updated with wdata byte k for each be[k]=1; other bytes keep their value.
  - be=0 is a legal no-op write.
  - oe is don't-care; write wins over oe.
- Read (IDLE, cs=1, we=0, oe=1):
  - READ_LATENCY=1: rdata=mem[addr] and rvalid=1 after that edge.
  - READ_LATENCY=2: rdata/rvalid appear one edge later.
  - Back-to-back reads give one result per cycle.
- Write cycle with WRITE_MODE=1: the merged word (old bytes + enabled new bytes) is returned with rvalid, using the same latency as a read.
- No access (cs=0, or we=0 with oe=0): rvalid=0 and rdata holds its last value.
- Out-of-range addr (addr >= DEPTH):
  - writes are dropped;
  - reads return 0 with rvalid=1.
- clr_req and a user access in the same cycle in IDLE: the user access is performed at that edge, then the sweep starts. Consequence: a write to address 0 in that cycle is overwritten by the sweep.
- Reset mid-sweep aborts the sweep: busy=0, FSM to IDLE. Locations already cleared stay cleared; the others keep their old data.
- Array implemented as reg array, synchronous write, registered read; inferable as block RAM.

Test Plan:
- Reset then write 16 words: addr i, data 16'hA500+i, be=2'b11. Then read 0..15 back to back -> rvalid every cycle, rdata=16'hA500+i with latency READ_LATENCY (run with 1 and 2).
- Byte enables: write 16'h1234 to addr 3, then write 16'hABCD with be=2'b10 -> read returns 16'hAB34. A be=2'b00 write leaves 16'hAB34.
- WRITE_MODE=1: write 16'hBEEF to addr 5 with be=2'b01 over 16'h1100 -> rdata=16'h11EF, rvalid=1 after the write edge. With WRITE_MODE=0, rvalid stays 0 and rdata holds.
- Clear sweep (CLR_VALUE=16'h00FF):
  - pulse clr_req -> busy=1 for exactly 16 cycles;
  - writes attempted during busy are dropped and give no rvalid;
  - afterwards all 16 reads return 16'h00FF.
- Reset mid-sweep: assert rst after 5 sweep cycles -> busy=0 and rvalid=0 immediately. Addrs 0..4 read 16'h00FF; addrs 5..15 keep their prior data.
- Idle/out-of-range:
  - cs=0 for 10 cycles -> rvalid=0, rdata unchanged;
  - with DEPTH=12, write to addr 13 then read addr 13 -> rdata=0, rvalid=1; addr 0..11 are unaffected.
